// File: rtl/count_seq_monitor_if.sv
// Sample/status bundle between a 4-bit counter tap and its sequence monitor.
// The master drives samples and clear requests; the slave (the monitor) drives status.
interface count_seq_monitor_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_valid;
  logic             err_clr;
  logic             locked;
  logic             wrap_pulse;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] wrap_count;
  logic [WIDTH-1:0] last_cnt;

  modport master (
    output cnt_in, cnt_valid, err_clr,
    input  locked, wrap_pulse, err_pulse, err_sticky, err_count, wrap_count, last_cnt
  );

  modport slave (
    input  cnt_in, cnt_valid, err_clr,
    output locked, wrap_pulse, err_pulse, err_sticky, err_count, wrap_count, last_cnt
  );
endinterface

// File: rtl/count_seq_monitor.sv
// Checks that a free-running counter advances by exactly one per valid sample,
// acquiring lock first, then reporting wraps and sequence errors (all registered).
module count_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic                  clk,
  input  logic                  res,
  count_seq_monitor_if.slave    bus
);

  typedef enum logic [1:0] {UNSYNC, ACQ, LOCKED} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_LEN);

  state_t           state_p1, state_nxt;
  logic [WIDTH-1:0] prev_p1, prev_nxt;
  logic [3:0]       run_p1, run_nxt;
  logic [WIDTH-1:0] exp_cnt;
  logic [3:0]       run_inc;
  logic             match;
  logic             wrap_ev, err_ev;

  logic             locked_p1, wrap_p1, err_p1, sticky_p1;
  logic [ERR_W-1:0] errc_p1, wrapc_p1;
  logic [WIDTH-1:0] last_p1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

  // Expected sample wraps naturally at WIDTH bits, so max+1 == 0.
  assign exp_cnt = prev_p1 + WIDTH'(1);
  assign run_inc = run_p1 + 4'd1;
  assign match   = (bus.cnt_in == exp_cnt);

  always_comb begin
    state_nxt = state_p1;
    prev_nxt  = prev_p1;
    run_nxt   = run_p1;
    wrap_ev   = 1'b0;
    err_ev    = 1'b0;
    if (bus.cnt_valid) begin
      prev_nxt = bus.cnt_in;
      unique case (state_p1)
        UNSYNC: begin
          run_nxt   = 4'd0;
          state_nxt = ACQ;
        end
        ACQ: begin
          if (match) begin
            run_nxt = run_inc;
            if (run_inc == LOCK_RUN) state_nxt = LOCKED;
          end else begin
            run_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_ev = (prev_p1 == CNT_MAX);
          end else begin
            err_ev    = 1'b1;
            run_nxt   = 4'd0;
            state_nxt = ACQ;
          end
        end
        default: state_nxt = UNSYNC;
      endcase
    end
  end

  // Stage 1: state and registered status outputs
  always_ff @(posedge clk) begin
    if (res) begin
      state_p1  <= UNSYNC;
      prev_p1   <= '0;
      run_p1    <= '0;
      locked_p1 <= 1'b0;
      wrap_p1   <= 1'b0;
      err_p1    <= 1'b0;
      sticky_p1 <= 1'b0;
      errc_p1   <= '0;
      wrapc_p1  <= '0;
      last_p1   <= '0;
    end else begin
      state_p1  <= state_nxt;
      prev_p1   <= prev_nxt;
      run_p1    <= run_nxt;
      locked_p1 <= (state_nxt == LOCKED);
      wrap_p1   <= wrap_ev;
      err_p1    <= err_ev;
      if (bus.cnt_valid) last_p1 <= bus.cnt_in;
      if (wrap_ev) wrapc_p1 <= wrapc_p1 + ERR_W'(1);
      // An error in the same cycle as a clear takes priority over the clear.
      if (err_ev) begin
        sticky_p1 <= 1'b1;
        errc_p1   <= bus.err_clr ? ERR_W'(1) : sat_inc(errc_p1);
      end else if (bus.err_clr) begin
        sticky_p1 <= 1'b0;
        errc_p1   <= '0;
      end
    end
  end

  assign bus.locked     = locked_p1;
  assign bus.wrap_pulse = wrap_p1;
  assign bus.err_pulse  = err_p1;
  assign bus.err_sticky = sticky_p1;
  assign bus.err_count  = errc_p1;
  assign bus.wrap_count = wrapc_p1;
  assign bus.last_cnt   = last_p1;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: lock, wrap, error/re-lock, gating,
// clear collision and mid-stream reset, with hand-computed expectations.
module tb_count_seq_monitor;
  localparam int WIDTH    = 4;
  localparam int LOCK_LEN = 3;
  localparam int ERR_W    = 8;

  logic clk;
  logic res;
  int   errors = 0;
  int   checks = 0;

  count_seq_monitor_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  count_seq_monitor #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic v, input logic clr);
    @(negedge clk);
    res           = 1'b0;
    bus.cnt_in    = c;
    bus.cnt_valid = v;
    bus.err_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] c, input logic v, input logic clr);
    @(negedge clk);
    res           = 1'b1;
    bus.cnt_in    = c;
    bus.cnt_valid = v;
    bus.err_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Feeds n consecutive valid samples from 'from' (mod 16); none may flag an error.
  task automatic feed(input int from, input int n);
    for (int i = 0; i < n; i++) begin
      step(4'(from + i), 1'b1, 1'b0);
      chk("feed_no_err", 32'(bus.err_pulse), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
    chk({tag, "_wrap_pulse"}, 32'(bus.wrap_pulse), 32'd0);
    chk({tag, "_err_pulse"}, 32'(bus.err_pulse), 32'd0);
    chk({tag, "_err_sticky"}, 32'(bus.err_sticky), 32'd0);
    chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    chk({tag, "_wrap_count"}, 32'(bus.wrap_count), 32'd0);
    chk({tag, "_last_cnt"}, 32'(bus.last_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    res           = 1'b1;
    bus.cnt_in    = '0;
    bus.cnt_valid = 1'b0;
    bus.err_clr   = 1'b0;

    // Reset state
    do_reset(4'd9, 1'b1, 1'b0);
    chk_all_zero("rst");

    // Lock after 0,1,2,3
    step(4'd0, 1'b1, 1'b0); chk("lock_s0", 32'(bus.locked), 32'd0);
    step(4'd1, 1'b1, 1'b0); chk("lock_s1", 32'(bus.locked), 32'd0);
    step(4'd2, 1'b1, 1'b0); chk("lock_s2", 32'(bus.locked), 32'd0);
    step(4'd3, 1'b1, 1'b0); chk("lock_s3", 32'(bus.locked), 32'd1);
    chk("lock_errc", 32'(bus.err_count), 32'd0);
    chk("lock_last", 32'(bus.last_cnt), 32'd3);

    // Wrap: 4..13, then 14,15,0,1
    feed(4, 10);
    step(4'd14, 1'b1, 1'b0); chk("wrap_s14", 32'(bus.wrap_pulse), 32'd0);
    step(4'd15, 1'b1, 1'b0); chk("wrap_s15", 32'(bus.wrap_pulse), 32'd0);
    step(4'd0, 1'b1, 1'b0);
    chk("wrap_s0_pulse", 32'(bus.wrap_pulse), 32'd1);
    chk("wrap_s0_count", 32'(bus.wrap_count), 32'd1);
    chk("wrap_s0_err", 32'(bus.err_pulse), 32'd0);
    step(4'd1, 1'b1, 1'b0);
    chk("wrap_s1_pulse", 32'(bus.wrap_pulse), 32'd0);
    chk("wrap_s1_err", 32'(bus.err_pulse), 32'd0);
    chk("wrap_s1_count", 32'(bus.wrap_count), 32'd1);

    // Error and re-lock: locked at 5, feed 6,9,10,11,12
    feed(2, 4);
    step(4'd6, 1'b1, 1'b0); chk("err_s6_locked", 32'(bus.locked), 32'd1);
    step(4'd9, 1'b1, 1'b0);
    chk("err_s9_pulse", 32'(bus.err_pulse), 32'd1);
    chk("err_s9_sticky", 32'(bus.err_sticky), 32'd1);
    chk("err_s9_count", 32'(bus.err_count), 32'd1);
    chk("err_s9_locked", 32'(bus.locked), 32'd0);
    chk("err_s9_wrap", 32'(bus.wrap_pulse), 32'd0);
    step(4'd10, 1'b1, 1'b0);
    chk("err_s10_pulse", 32'(bus.err_pulse), 32'd0);
    chk("err_s10_locked", 32'(bus.locked), 32'd0);
    step(4'd11, 1'b1, 1'b0); chk("err_s11_locked", 32'(bus.locked), 32'd0);
    step(4'd12, 1'b1, 1'b0); chk("err_s12_locked", 32'(bus.locked), 32'd1);
    chk("err_s12_count", 32'(bus.err_count), 32'd1);

    // Valid gating: advance to 7 (one more wrap), hold 3 cycles with cnt_in=0, then 8
    feed(13, 11);
    chk("gate_wrapc", 32'(bus.wrap_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(4'd0, 1'b0, 1'b0);
      chk("gate_hold_err", 32'(bus.err_pulse), 32'd0);
      chk("gate_hold_locked", 32'(bus.locked), 32'd1);
      chk("gate_hold_last", 32'(bus.last_cnt), 32'd7);
    end
    step(4'd8, 1'b1, 1'b0);
    chk("gate_s8_err", 32'(bus.err_pulse), 32'd0);
    chk("gate_s8_last", 32'(bus.last_cnt), 32'd8);
    chk("gate_s8_locked", 32'(bus.locked), 32'd1);
    chk("gate_s8_errc", 32'(bus.err_count), 32'd1);

    // Clear collision: second error, re-lock, then mismatch with err_clr
    step(4'd3, 1'b1, 1'b0);
    chk("clr_err2_count", 32'(bus.err_count), 32'd2);
    feed(4, 3);
    chk("clr_relock", 32'(bus.locked), 32'd1);
    step(4'd0, 1'b1, 1'b1);
    chk("clr_coll_pulse", 32'(bus.err_pulse), 32'd1);
    chk("clr_coll_count", 32'(bus.err_count), 32'd1);
    chk("clr_coll_sticky", 32'(bus.err_sticky), 32'd1);
    step(4'd1, 1'b1, 1'b1);
    chk("clr_lone_count", 32'(bus.err_count), 32'd0);
    chk("clr_lone_sticky", 32'(bus.err_sticky), 32'd0);

    // Build up err_count=3, wrap_count=5 while ending locked
    feed(2, 2);
    chk("build_locked", 32'(bus.locked), 32'd1);
    feed(4, 13);                       // 4..15,0 -> wrap 3
    step(4'd5, 1'b1, 1'b0);            // error 1
    feed(6, 3);                        // lock at 8
    feed(9, 8);                        // 9..15,0 -> wrap 4
    step(4'd7, 1'b1, 1'b0);            // error 2
    feed(8, 3);                        // lock at 10
    feed(11, 6);                       // 11..15,0 -> wrap 5
    step(4'd9, 1'b1, 1'b0);            // error 3
    feed(10, 3);                       // lock at 12
    chk("pre_rst_locked", 32'(bus.locked), 32'd1);
    chk("pre_rst_errc", 32'(bus.err_count), 32'd3);
    chk("pre_rst_wrapc", 32'(bus.wrap_count), 32'd5);
    chk("pre_rst_sticky", 32'(bus.err_sticky), 32'd1);

    // Mid-stream reset overrides valid sample and err_clr
    do_reset(4'd13, 1'b1, 1'b1);
    chk_all_zero("mid_rst");
    step(4'd4, 1'b1, 1'b0); chk("rel_s4_locked", 32'(bus.locked), 32'd0);
    chk("rel_s4_err", 32'(bus.err_pulse), 32'd0);
    step(4'd5, 1'b1, 1'b0); chk("rel_s5_locked", 32'(bus.locked), 32'd0);
    chk("rel_s5_err", 32'(bus.err_pulse), 32'd0);
    step(4'd6, 1'b1, 1'b0); chk("rel_s6_locked", 32'(bus.locked), 32'd0);
    chk("rel_s6_err", 32'(bus.err_pulse), 32'd0);
    step(4'd7, 1'b1, 1'b0); chk("rel_s7_locked", 32'(bus.locked), 32'd1);
    chk("rel_s7_errc", 32'(bus.err_count), 32'd0);
    chk("rel_s7_last", 32'(bus.last_cnt), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
